// File: rtl/host_slot_demux_pkg.sv
// Shared packet constants for the host byte-stream demultiplexer.
// Header[3:0] carries the packet kind; only audio and control kinds are routable.
package host_slot_demux_pkg;

    localparam logic [3:0] PKT_KIND_AUDIO = 4'd0;
    localparam logic [3:0] PKT_KIND_CTL   = 4'd1;

    function automatic logic kind_is_valid(input logic [3:0] kind);
        return (kind == PKT_KIND_AUDIO) || (kind == PKT_KIND_CTL);
    endfunction

endpackage

// File: rtl/host_slot_demux_byte_reg_slice.sv
// Single-entry valid/ready register slice: full throughput, no combinational path
// from the input data/valid to the output.
module byte_reg_slice #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    // Accept a new byte in the same cycle the held one is taken.
    assign in_ready_o = !valid_q || out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/host_slot_demux.sv
// Parses header/length/payload packets from the host byte stream and routes the
// payload bytes to one slot's audio or control stream through a one-byte output register.
module host_slot_demux
    import host_slot_demux_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                 clk_core,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic [NUM_SLOTS-1:0] aud_valid,
    output logic [7:0]           aud_data,
    input  logic [NUM_SLOTS-1:0] aud_ready,
    output logic [NUM_SLOTS-1:0] ctl_valid,
    output logic [7:0]           ctl_data,
    input  logic [NUM_SLOTS-1:0] ctl_ready,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned OBUF_W = 8 + SLOT_W + 1;

    localparam logic [2:0] ST_HDR     = 3'd0;
    localparam logic [2:0] ST_LEN_HI  = 3'd1;
    localparam logic [2:0] ST_LEN_LO  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  err_q, err_d;
    logic        busy_q, busy_d;

    logic              hdr_ok, is_ctl, accept, push, obuf_in_ready, obuf_valid, obuf_taken;
    logic [SLOT_W-1:0] slot_sel, out_slot;
    logic              out_is_ctl;
    logic [7:0]        out_byte;
    logic [OBUF_W-1:0] obuf_data;
    logic [15:0]       len_full;

    assign hdr_ok   = (32'(hdr_q[7:4]) < NUM_SLOTS) && kind_is_valid(hdr_q[3:0]);
    assign is_ctl   = (hdr_q[3:0] == PKT_KIND_CTL);
    assign slot_sel = SLOT_W'(hdr_q[7:4]);
    assign len_full = {len_hi_q, in_data};

    assign in_ready = (state_q == ST_PAYLOAD) ? obuf_in_ready : 1'b1;
    assign accept   = in_valid && in_ready;
    assign push     = (state_q == ST_PAYLOAD) && in_valid;

    // Slot/kind travel with the byte so a following header cannot re-route it.
    byte_reg_slice #(
        .Width(OBUF_W)
    ) u_obuf (
        .clk_i      (clk_core),
        .rst_ni     (reset),
        .in_valid_i (push),
        .in_data_i  ({is_ctl, slot_sel, in_data}),
        .in_ready_o (obuf_in_ready),
        .out_valid_o(obuf_valid),
        .out_data_o (obuf_data),
        .out_ready_i(obuf_taken)
    );

    assign {out_is_ctl, out_slot, out_byte} = obuf_data;

    always_comb begin
        aud_valid = '0;
        ctl_valid = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            aud_valid[s] = obuf_valid && !out_is_ctl && (out_slot == SLOT_W'(s));
            ctl_valid[s] = obuf_valid && out_is_ctl && (out_slot == SLOT_W'(s));
        end
    end

    assign obuf_taken = |((aud_valid & aud_ready) | (ctl_valid & ctl_ready));
    assign aud_data   = out_byte;
    assign ctl_data   = out_byte;

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        len_hi_d = len_hi_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        busy_d   = busy_q;
        unique case (state_q)
            ST_HDR: begin
                if (accept) begin
                    hdr_d   = in_data;
                    busy_d  = 1'b1;
                    state_d = ST_LEN_HI;
                end else if (!obuf_valid) begin
                    busy_d = 1'b0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    cnt_d = len_full;
                    if (!hdr_ok && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                    if (len_full == 16'd0) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = hdr_ok ? ST_PAYLOAD : ST_DISCARD;
                    end
                end
            end
            ST_PAYLOAD, ST_DISCARD: begin
                if (accept) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (!reset) begin
            state_q  <= ST_HDR;
            hdr_q    <= '0;
            len_hi_q <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            len_hi_q <= len_hi_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_host_slot_demux.sv
// Directed bench for host_slot_demux: routing, stalls, invalid/zero-length packets,
// back-to-back headers, mid-packet reset and a long packet under random ready.
module tb_host_slot_demux;

    logic       clk_core = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] aud_valid, aud_ready, ctl_valid, ctl_ready;
    logic [7:0] aud_data, ctl_data, err_count;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk_core = ~clk_core;

    host_slot_demux #(.NUM_SLOTS(4)) dut (
        .clk_core (clk_core),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .aud_valid(aud_valid),
        .aud_data (aud_data),
        .aud_ready(aud_ready),
        .ctl_valid(ctl_valid),
        .ctl_data (ctl_data),
        .ctl_ready(ctl_ready),
        .busy     (busy),
        .err_count(err_count)
    );

    // Delivered bytes: code = is_ctl*1024 + slot*256 + data, tagged with cycle number.
    typedef struct {int cyc; int code;} ev_t;
    ev_t evq[$];
    int  cyc = 0;
    int  busy_falls = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk_core) cyc++;

    always @(negedge clk_core) begin
        for (int s = 0; s < 4; s++) begin
            if (aud_valid[s] === 1'b1 && aud_ready[s]) evq.push_back('{cyc, s * 256 + int'(aud_data)});
            if (ctl_valid[s] === 1'b1 && ctl_ready[s]) evq.push_back('{cyc, 1024 + s * 256 + int'(ctl_data)});
        end
        if (busy_prev && busy === 1'b0) busy_falls++;
        busy_prev = (busy === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_core);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   t;
        logic acc;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (1) begin
            @(negedge clk_core);
            acc = in_ready;
            @(posedge clk_core);
            #1;
            if (acc === 1'b1) break;
            t++;
            if (t > 2000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=stalled exp=accepted byte=%h", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        aud_ready = 4'hF;
        ctl_ready = 4'hF;
        idle(3);
        @(negedge clk_core);
        checks++; if (aud_valid !== 4'b0) begin failures++; $display("FAIL reset_aud_valid got=%b exp=0000", aud_valid); end
        checks++; if (ctl_valid !== 4'b0) begin failures++; $display("FAIL reset_ctl_valid got=%b exp=0000", ctl_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk_core); #1;
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_audio;
        int exp_codes[3];
        int got, span;
        exp_codes = '{2 * 256 + 'hAA, 2 * 256 + 'hBB, 2 * 256 + 'hCC};
        evq.delete();
        busy_falls = 0;
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        idle(4);
        @(negedge clk_core);
        checks++; if (evq.size() !== 3) begin failures++; $display("FAIL audio_count got=%0d exp=3", evq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < evq.size()) ? evq[i].code : -1;
            checks++; if (got !== exp_codes[i]) begin failures++; $display("FAIL audio_byte%0d got=%h exp=%h", i, got, exp_codes[i]); end
        end
        span = (evq.size() >= 3) ? evq[2].cyc - evq[0].cyc : -1;
        checks++; if (span !== 2) begin failures++; $display("FAIL audio_consecutive got=%0d exp=2", span); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL audio_busy_end got=%b exp=0", busy); end
        checks++; if (busy_falls !== 1) begin failures++; $display("FAIL audio_busy_falls got=%0d exp=1", busy_falls); end
        @(posedge clk_core); #1;
    endtask

    task automatic test_ctl_stall;
        int got;
        evq.delete();
        ctl_ready = 4'b1101;
        fork
            begin
                send_byte(8'h11); send_byte(8'h00); send_byte(8'h02);
                send_byte(8'h05); send_byte(8'h7F);
            end
            begin
                int t;
                t = 0;
                @(negedge clk_core);
                while (ctl_valid === 4'b0 && t < 50) begin
                    @(negedge clk_core);
                    t++;
                end
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk_core);
                    checks++; if (ctl_valid !== 4'b0010) begin failures++; $display("FAIL stall_ctl_valid%0d got=%b exp=0010", i, ctl_valid); end
                    checks++; if (ctl_data !== 8'h05) begin failures++; $display("FAIL stall_ctl_data%0d got=%h exp=05", i, ctl_data); end
                    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready%0d got=%b exp=0", i, in_ready); end
                end
                @(posedge clk_core); #1;
                ctl_ready = 4'hF;
            end
        join
        idle(3);
        @(negedge clk_core);
        checks++; if (evq.size() !== 2) begin failures++; $display("FAIL stall_count got=%0d exp=2", evq.size()); end
        got = (evq.size() > 0) ? evq[0].code : -1;
        checks++; if (got !== 1024 + 256 + 'h05) begin failures++; $display("FAIL stall_first got=%h exp=%h", got, 1024 + 256 + 'h05); end
        got = (evq.size() > 1) ? evq[1].code : -1;
        checks++; if (got !== 1024 + 256 + 'h7F) begin failures++; $display("FAIL stall_second got=%h exp=%h", got, 1024 + 256 + 'h7F); end
        @(posedge clk_core); #1;
    endtask

    task automatic test_zero_len;
        int got;
        evq.delete();
        send_byte(8'h31); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h30); send_byte(8'h00); send_byte(8'h01); send_byte(8'hEE);
        idle(3);
        @(negedge clk_core);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL zero_count got=%0d exp=1", evq.size()); end
        got = (evq.size() > 0) ? evq[0].code : -1;
        checks++; if (got !== 3 * 256 + 'hEE) begin failures++; $display("FAIL zero_byte got=%h exp=%h", got, 3 * 256 + 'hEE); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL zero_err got=%0d exp=0", err_count); end
        @(posedge clk_core); #1;
    endtask

    task automatic test_invalid;
        int got;
        evq.delete();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        idle(2);
        @(negedge clk_core);
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL invalid_slot_err got=%0d exp=1", err_count); end
        checks++; if (evq.size() !== 0) begin failures++; $display("FAIL invalid_slot_output got=%0d exp=0", evq.size()); end
        @(posedge clk_core); #1;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'hDD);
        // Valid slot, unknown kind: also discarded and counted.
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h01); send_byte(8'h33);
        idle(3);
        @(negedge clk_core);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL invalid_count got=%0d exp=1", evq.size()); end
        got = (evq.size() > 0) ? evq[0].code : -1;
        checks++; if (got !== 'hDD) begin failures++; $display("FAIL invalid_next_byte got=%h exp=%h", got, 'hDD); end
        checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL invalid_kind_err got=%0d exp=2", err_count); end
        @(posedge clk_core); #1;
    endtask

    task automatic test_back_to_back;
        int got;
        evq.delete();
        aud_ready = 4'b1101;
        fork
            begin
                send_byte(8'h10); send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
                send_byte(8'h20); send_byte(8'h00); send_byte(8'h01); send_byte(8'h88);
            end
            begin
                repeat (12) @(posedge clk_core);
                @(negedge clk_core);
                checks++; if (aud_valid !== 4'b0010) begin failures++; $display("FAIL b2b_held_valid got=%b exp=0010", aud_valid); end
                checks++; if (aud_data !== 8'h77) begin failures++; $display("FAIL b2b_held_data got=%h exp=77", aud_data); end
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready got=%b exp=0", in_ready); end
                @(posedge clk_core); #1;
                aud_ready = 4'hF;
            end
        join
        idle(3);
        @(negedge clk_core);
        checks++; if (evq.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", evq.size()); end
        got = (evq.size() > 0) ? evq[0].code : -1;
        checks++; if (got !== 256 + 'h77) begin failures++; $display("FAIL b2b_first got=%h exp=%h", got, 256 + 'h77); end
        got = (evq.size() > 1) ? evq[1].code : -1;
        checks++; if (got !== 512 + 'h88) begin failures++; $display("FAIL b2b_second got=%h exp=%h", got, 512 + 'h88); end
        @(posedge clk_core); #1;
    endtask

    task automatic test_reset_mid;
        int got;
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h03); send_byte(8'hAA);
        reset = 1'b0;
        @(posedge clk_core); #1;
        reset = 1'b1;
        @(negedge clk_core);
        checks++; if (aud_valid !== 4'b0) begin failures++; $display("FAIL midrst_aud_valid got=%b exp=0000", aud_valid); end
        checks++; if (ctl_valid !== 4'b0) begin failures++; $display("FAIL midrst_ctl_valid got=%b exp=0000", ctl_valid); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL midrst_err got=%0d exp=0", err_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        @(posedge clk_core); #1;
        evq.delete();
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h01); send_byte(8'h44);
        idle(3);
        @(negedge clk_core);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", evq.size()); end
        got = (evq.size() > 0) ? evq[0].code : -1;
        checks++; if (got !== 256 + 'h44) begin failures++; $display("FAIL midrst_byte got=%h exp=%h", got, 256 + 'h44); end
        @(posedge clk_core); #1;
    endtask

    task automatic test_long;
        int   bad;
        logic done;
        evq.delete();
        busy_falls = 0;
        done = 1'b0;
        fork
            begin
                send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
                for (int i = 0; i < 256; i++) send_byte(8'(i));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_core); #1;
                    aud_ready = {3'b111, 1'($urandom_range(0, 1))};
                end
                aud_ready = 4'hF;
            end
        join
        idle(5);
        @(negedge clk_core);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i >= evq.size()) bad++;
            else if (evq[i].code != i) bad++;
        end
        checks++; if (evq.size() !== 256) begin failures++; $display("FAIL long_count got=%0d exp=256", evq.size()); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL long_order got=%0d_bad exp=0_bad", bad); end
        checks++; if (busy_falls !== 1) begin failures++; $display("FAIL long_busy_falls got=%0d exp=1", busy_falls); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL long_busy_end got=%b exp=0", busy); end
        @(posedge clk_core); #1;
    endtask

    initial begin
        test_reset();
        test_audio();
        test_ctl_stall();
        test_zero_len();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
